// File: rtl/p08_spi_pkg.sv
// Shared command codes, payload lengths and frame packing for the SPI command
// link between this transmitter and the register-file receiver.
package p08_spi_pkg;

    localparam int unsigned CMD_W    = 4;
    localparam int unsigned DATA_W   = 24;
    localparam int unsigned FRAME_W  = CMD_W + DATA_W;
    localparam int unsigned BITCNT_W = 5;

    localparam logic [3:0] CMD_SKY      = 4'd0;
    localparam logic [3:0] CMD_GROUND   = 4'd1;
    localparam logic [3:0] CMD_FOG      = 4'd2;
    localparam logic [3:0] CMD_OTHERXY  = 4'd3;
    localparam logic [3:0] CMD_HAZE     = 4'd4;
    localparam logic [3:0] CMD_VINF     = 4'd5;
    localparam logic [3:0] CMD_MAPD     = 4'd6;
    localparam logic [3:0] CMD_TEXADD0  = 4'd7;
    localparam logic [3:0] CMD_TEXADD1  = 4'd8;
    localparam logic [3:0] CMD_TEXADD2  = 4'd9;
    localparam logic [3:0] CMD_TEXADD3  = 4'd10;
    localparam logic [3:0] CMD_LOAD_NEW = 4'd11;
    localparam logic [3:0] CMD_STROBE0  = 4'd12;
    localparam logic [3:0] CMD_STROBE1  = 4'd13;
    localparam logic [3:0] CMD_STROBE2  = 4'd14;
    localparam logic [3:0] CMD_STROBE3  = 4'd15;

    localparam logic [BITCNT_W-1:0] LEN_SHORT = 5'd6;
    localparam logic [BITCNT_W-1:0] LEN_PAIR  = 5'd12;
    localparam logic [BITCNT_W-1:0] LEN_FLAG  = 5'd1;
    localparam logic [BITCNT_W-1:0] LEN_MAP   = 5'd16;
    localparam logic [BITCNT_W-1:0] LEN_ADDR  = 5'd24;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    function automatic logic [BITCNT_W-1:0] cmd_len(input logic [CMD_W-1:0] cmd);
        logic [BITCNT_W-1:0] len;
        case (cmd)
            CMD_SKY, CMD_GROUND, CMD_FOG, CMD_HAZE:            len = LEN_SHORT;
            CMD_OTHERXY:                                       len = LEN_PAIR;
            CMD_VINF:                                          len = LEN_FLAG;
            CMD_MAPD:                                          len = LEN_MAP;
            CMD_TEXADD0, CMD_TEXADD1, CMD_TEXADD2, CMD_TEXADD3: len = LEN_ADDR;
            default:                                           len = LEN_FLAG;
        endcase
        return len;
    endfunction

    // Left-align the used payload bits under the command so the frame always
    // shifts out of the MSB; the left shift also drops the unused upper bits.
    function automatic spi_frame_t pack_frame(input logic [CMD_W-1:0] cmd,
                                              input logic [DATA_W-1:0] data);
        spi_frame_t f;
        f.cmd  = cmd;
        f.data = data << (BITCNT_W'(DATA_W) - cmd_len(cmd));
        return f;
    endfunction

endpackage

// File: rtl/p08_spi_tick.sv
// Per-state cycle counter for the SPI transmitter; restarts on clear.
module p08_spi_tick #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/p08_spi_cmd_tx.sv
// SPI mode-0 command transmitter: frames {cmd, data[LEN-1:0]} MSB-first with
// a fixed slave-select gap between frames.
module p08_spi_cmd_tx
    import p08_spi_pkg::*;
#(
    parameter int unsigned HALF   = 4,
    parameter int unsigned SS_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_cmd,
    input  logic [23:0] i_data,
    output logic        o_sclk,
    output logic        o_ss_n,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned CNT_MAX = (HALF > SS_GAP) ? HALF : SS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SS_GAP - 1);
    localparam logic [CNT_W-1:0] DONE_AT   = CNT_W'(SS_GAP - 2);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_TAIL = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [CNT_W-1:0]    tick;
    logic                cnt_clear;
    logic [FRAME_W-1:0]  sr;
    logic [FRAME_W-1:0]  sr_d;
    logic [BITCNT_W-1:0] bits;
    logic [BITCNT_W-1:0] bits_d;
    logic [BITCNT_W-1:0] nbits;
    logic [BITCNT_W-1:0] nbits_d;
    logic                mosi_d;

    p08_spi_tick #(.W(CNT_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .count (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
            bits  <= '0;
            nbits <= '0;
        end else begin
            state <= next_state;
            sr    <= sr_d;
            bits  <= bits_d;
            nbits <= nbits_d;
        end
    end

    // Next state, shift/bit-count updates and the next MOSI value.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        sr_d       = sr;
        bits_d     = bits;
        nbits_d    = nbits;
        mosi_d     = o_mosi;
        case (state)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (i_valid) begin
                    next_state = ST_LOW;
                    sr_d       = pack_frame(i_cmd, i_data);
                    bits_d     = '0;
                    nbits_d    = BITCNT_W'(CMD_W) + cmd_len(i_cmd);
                    mosi_d     = i_cmd[CMD_W-1];
                end
            end
            ST_LOW: begin
                if (tick == HALF_LAST) begin
                    next_state = ST_HIGH;
                    cnt_clear  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick == HALF_LAST) begin
                    cnt_clear = 1'b1;
                    sr_d      = {sr[FRAME_W-2:0], 1'b0};
                    bits_d    = (bits == '1) ? bits : bits + BITCNT_W'(1);
                    if (bits_d == nbits) begin
                        next_state = ST_TAIL;
                    end else begin
                        next_state = ST_LOW;
                        mosi_d     = sr[FRAME_W-2];
                    end
                end
            end
            ST_TAIL: begin
                if (tick == HALF_LAST) begin
                    next_state = ST_GAP;
                    cnt_clear  = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick == GAP_LAST) begin
                    next_state = ST_IDLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    // Pins are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_ss_n  <= 1'b1;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_ready <= (next_state == ST_IDLE);
            o_busy  <= (next_state != ST_IDLE);
            o_ss_n  <= (next_state == ST_IDLE) || (next_state == ST_GAP);
            o_sclk  <= (next_state == ST_HIGH);
            o_mosi  <= mosi_d;
            o_done  <= (state == ST_GAP) && (tick == DONE_AT);
        end
    end

endmodule
